// File: rtl/ts_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_ctl_if : Z80 I/O bus fields seen by the TurboSound front-end       |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
interface ts_ctl_if;
  logic [15:0] a;
  logic [7:0]  d;
  logic        ioreq;
  logic        wr;
  logic        rd;

  modport master (output a, d, ioreq, wr, rd);
  modport slave  (input  a, d, ioreq, wr, rd);
endinterface
`default_nettype wire

// File: rtl/ts_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_ctl   : TurboSound front-end, AY port decode, strobes, AY clock    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module ts_ctl #(
  parameter bit TS_DEFAULT = 1'b0
) (
  input  logic      clk28,
  input  logic      rst,
  ts_ctl_if.slave   bus,
  input  logic      ck35,
  input  logic      ts_en,
  output logic      ay_clk,
  output logic      ay_bc1,
  output logic      ay_bdir,
  output logic      ay_sel,
  output logic      ay_rd_oe
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWALLOW = 2'd1,
    ST_PASS    = 2'd2
  } state_t;

  state_t r_state;
  logic   r_bc1_l;
  logic   r_bdir_l;
  logic   r_rdoe_l;
  logic   r_sel;
  logic   r_bc1;
  logic   r_bdir;
  logic   r_rd_oe;
  logic   r_ay_clk;

  logic w_hit;
  logic w_addr_sel;
  logic w_sel_wr;
  logic w_unused;

  assign w_hit      = bus.ioreq & bus.a[15] & ~bus.a[1];
  assign w_addr_sel = w_hit & bus.a[14];
  assign w_sel_wr   = w_addr_sel & bus.wr & ts_en & (bus.d[7:1] == 7'h7F);
  assign w_unused   = &{1'b0, bus.a[13:2], bus.a[0]};

  // Strobes follow the state one clock late so they are glitch-free register outputs.
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bc1_l  <= 1'b0;
      r_bdir_l <= 1'b0;
      r_rdoe_l <= 1'b0;
      r_sel    <= TS_DEFAULT;
      r_bc1    <= 1'b0;
      r_bdir   <= 1'b0;
      r_rd_oe  <= 1'b0;
    end else begin
      r_bc1   <= (r_state == ST_PASS) & r_bc1_l;
      r_bdir  <= (r_state == ST_PASS) & r_bdir_l;
      r_rd_oe <= (r_state == ST_PASS) & r_rdoe_l;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_wr) begin
            r_state <= ST_SWALLOW;
            r_sel   <= ~bus.d[0];
          end else if (w_hit & (bus.wr | bus.rd)) begin
            r_state  <= ST_PASS;
            r_bc1_l  <= w_addr_sel | (bus.rd & bus.a[14]);
            r_bdir_l <= bus.wr;
            r_rdoe_l <= bus.rd & w_addr_sel;
          end
        end
        ST_SWALLOW, ST_PASS: begin
          if (!bus.ioreq) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_ay_clk <= 1'b0;
    end else if (ck35) begin
      r_ay_clk <= ~r_ay_clk;
    end
  end

  // With TurboSound off the board behaves as a single AY0; the stored choice survives.
  assign ay_sel   = ts_en & r_sel;
  assign ay_bc1   = r_bc1;
  assign ay_bdir  = r_bdir;
  assign ay_rd_oe = r_rd_oe;
  assign ay_clk   = r_ay_clk;

endmodule
`default_nettype wire

// File: tb/tb_ts_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ts_ctl : directed bench for ts_ctl with a transaction-level model  |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_ts_ctl;
  localparam bit TS_DEFAULT = 1'b0;

  logic clk28 = 1'b0;
  logic rst;
  logic ck35;
  logic ts_en;
  logic ay_clk;
  logic ay_bc1;
  logic ay_bdir;
  logic ay_sel;
  logic ay_rd_oe;

  int n_checks = 0;
  int n_fail   = 0;
  bit ck_on    = 1'b0;
  int ck_cnt   = 0;

  ts_ctl_if bus ();

  ts_ctl #(.TS_DEFAULT(TS_DEFAULT)) dut (
    .clk28    (clk28),
    .rst      (rst),
    .bus      (bus),
    .ck35     (ck35),
    .ts_en    (ts_en),
    .ay_clk   (ay_clk),
    .ay_bc1   (ay_bc1),
    .ay_bdir  (ay_bdir),
    .ay_sel   (ay_sel),
    .ay_rd_oe (ay_rd_oe)
  );

  always #5 clk28 = ~clk28;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // 3.5 MHz enable: one clk28 wide, every 8th clk28
  always @(negedge clk28) begin
    if (ck_on) begin
      ck_cnt++;
      ck35 = (ck_cnt % 8 == 0);
    end else begin
      ck35 = 1'b0;
    end
  end

  // Model: one record per I/O cycle, decision taken from the AY strobe table.
  bit m_busy, m_pass, m_bc1, m_bdir, m_oe, m_sel;
  bit e_bc1, e_bdir, e_oe, e_clk;
  bit chk_en = 1'b0;

  always begin
    bit fffd;
    @(posedge clk28);
    if (rst) begin
      m_busy = 0; m_pass = 0; m_sel = TS_DEFAULT;
      e_bc1 = 0; e_bdir = 0; e_oe = 0; e_clk = 0;
      chk_en = 1'b1;
    end else begin
      e_bc1  = m_busy && m_pass && m_bc1;
      e_bdir = m_busy && m_pass && m_bdir;
      e_oe   = m_busy && m_pass && m_oe;
      if (ck35) e_clk = !e_clk;
      if (!m_busy) begin
        if (bus.ioreq && bus.a[15] && !bus.a[1]) begin
          fffd = bus.a[14];
          if (fffd && bus.wr && ts_en && bus.d[7:1] == 7'h7F) begin
            m_busy = 1; m_pass = 0; m_sel = !bus.d[0];
          end else if (bus.wr) begin
            m_busy = 1; m_pass = 1; m_bdir = 1; m_bc1 = fffd; m_oe = 0;
          end else if (bus.rd) begin
            m_busy = 1; m_pass = 1; m_bdir = 0; m_bc1 = fffd; m_oe = fffd;
          end
        end
      end else if (!bus.ioreq) begin
        m_busy = 0;
      end
    end
    #1;
    if (chk_en) begin
      check("cyc_bc1",   ay_bc1,   e_bc1);
      check("cyc_bdir",  ay_bdir,  e_bdir);
      check("cyc_rd_oe", ay_rd_oe, e_oe);
      check("cyc_clk",   ay_clk,   e_clk);
      check("cyc_sel",   ay_sel,   ts_en & m_sel);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic bus_start(input logic [15:0] addr, input logic [7:0] data, input bit w);
    bus.a = addr; bus.d = data; bus.wr = w; bus.rd = !w; bus.ioreq = 1'b1;
  endtask

  task automatic bus_end();
    bus.ioreq = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic io(input string name, input logic [15:0] addr, input logic [7:0] data,
                    input bit w, input bit x_bc1, input bit x_bdir, input bit x_oe);
    bus_start(addr, data, w);
    step(2);
    check({name, "_bc1"},  ay_bc1,   x_bc1);
    check({name, "_bdir"}, ay_bdir,  x_bdir);
    check({name, "_oe"},   ay_rd_oe, x_oe);
    step(2);
    bus_end();
    step(3);
  endtask

  initial begin
    int toggles;
    logic prev;
    rst = 1'b1; ts_en = 1'b1; ck35 = 1'b0;
    bus.a = '0; bus.d = '0; bus.ioreq = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    step(3);
    check("rst_bc1",  ay_bc1,   1'b0);
    check("rst_bdir", ay_bdir,  1'b0);
    check("rst_clk",  ay_clk,   1'b0);
    check("rst_oe",   ay_rd_oe, 1'b0);
    check("rst_sel",  ay_sel,   TS_DEFAULT);
    rst = 1'b0;
    ck_on = 1'b1;
    step(2);

    // OUT (#FFFD),#07: latch address, check one-clock latency on both edges
    bus_start(16'hFFFD, 8'h07, 1'b1);
    step(1);
    check("adr_early_bc1", ay_bc1, 1'b0);
    step(1);
    check("adr_bc1",  ay_bc1,  1'b1);
    check("adr_bdir", ay_bdir, 1'b1);
    step(2);
    bus_end();
    step(1);
    check("adr_tail_bc1", ay_bc1, 1'b1);
    step(1);
    check("adr_off_bc1", ay_bc1, 1'b0);
    check("adr_sel", ay_sel, 1'b0);
    step(2);

    io("swfe", 16'hFFFD, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("swfe_sel", ay_sel, 1'b1);
    io("dat", 16'hBFFD, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    check("dat_sel", ay_sel, 1'b1);

    // TurboSound off: #FF passes as an address write, stored select untouched
    ts_en = 1'b0;
    step(1);
    check("tsoff_sel", ay_sel, 1'b0);
    io("tsoff", 16'hFFFD, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
    check("tsoff_sel2", ay_sel, 1'b0);
    ts_en = 1'b1;
    step(1);
    check("tson_sel", ay_sel, 1'b1);

    io("rdreg", 16'hFFFD, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    io("rddat", 16'hBFFD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    io("p7ffd", 16'h7FFD, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);

    // Data changes after decode: the swallow decision must hold
    bus_start(16'hFFFD, 8'hFF, 1'b1);
    step(2);
    bus.d = 8'h00;
    step(1);
    check("late_d_bc1",  ay_bc1,  1'b0);
    check("late_d_bdir", ay_bdir, 1'b0);
    step(2);
    bus_end();
    step(3);
    check("late_d_sel", ay_sel, 1'b0);

    io("swfe2", 16'hFFFD, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("swfe2_sel", ay_sel, 1'b1);

    // Reset in the middle of a PASS cycle, then re-decode while ioreq stays high
    bus_start(16'hFFFD, 8'h07, 1'b1);
    step(2);
    check("prerst_bc1", ay_bc1, 1'b1);
    rst = 1'b1;
    step(1);
    check("midrst_bc1", ay_bc1, 1'b0);
    check("midrst_sel", ay_sel, TS_DEFAULT);
    rst = 1'b0;
    step(2);
    check("redecode_bc1", ay_bc1, 1'b1);
    bus_end();
    step(3);

    // AY clock over 64 clk28 with a concurrent bus cycle: 8 toggles expected
    toggles = 0;
    prev = ay_clk;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) bus_start(16'hFFFD, 8'h05, 1'b1);
      if (i == 20) bus_end();
      step(1);
      if (ay_clk !== prev) toggles++;
      prev = ay_clk;
    end
    n_checks++;
    if (toggles != 8) begin
      n_fail++;
      $display("FAIL ayclk_toggles: got %0d, expected 8", toggles);
    end
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
